collision_engine: RTL and testbench
===================================

COLLISION_ENGINE -- requirements
Module: collision_engine

Interface
REQ-001 Parameter GRID_W, default 160, framebuffer width in pixels (x range).
REQ-002 Parameter GRID_H, default 120, framebuffer height in pixels (y range).
REQ-003 Parameter N_ENEMY, default 4, number of enemy channels checked per tick.
REQ-004 Parameter TICK_DIV, default 1_500_000, clock cycles per collision tick; legal only if TICK_DIV >= N_ENEMY+4.
REQ-005 Parameter HIT_RADIUS, default 2, user/enemy overlap half-width in pixels.
REQ-006 Parameter HEALTH_INIT, default 3, health value after reset or game start.
REQ-007 clock  in  1  sole clock; all state on rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 start_game  in  1  synchronous clear of tick counter, score, health, flags; wins over all other activity.
REQ-010 grid  in  GRID_W*GRID_H  projectile bitmap; pixel (x,y) is bit GRID_H*x+y.
REQ-011 user_x  in  8  player x.  user_y  in  7  player y.
REQ-012 enemy_x  in  8*N_ENEMY  packed, channel i at bits [8i+7:8i].  enemy_y  in  7*N_ENEMY  packed likewise.
REQ-013 enemy_valid  in  N_ENEMY  channel i alive.
REQ-014 score_update  out  1  one-cycle pulse, >=1 enemy hit this tick.
REQ-015 health_update  out  1  one-cycle pulse, player struck this tick.
REQ-016 hit_mask  out  N_ENEMY  enemies hit on last completed tick; held until next completion.
REQ-017 score  out  16  accumulated hits.  health  out  4  remaining health.
REQ-018 game_over  out  1  high while health==0.  busy  out  1  high in SCAN or REPORT.
REQ-019 tick_overrun  out  1  sticky; a tick arrived while busy.

Function
REQ-020 Tick counter SHALL load TICK_DIV-1, decrement each cycle, assert internal tick for one cycle on 0 and reload.
REQ-021 FSM states SHALL be IDLE, SCAN, REPORT; reset state IDLE.
REQ-022 IDLE: on tick with game_over low, SHALL snapshot user_x/y, enemy_x/y, enemy_valid, clear scan accumulators, set index 0, go SCAN; on tick with game_over high, stay IDLE.
REQ-023 SCAN: one enemy per cycle; after index N_ENEMY-1 go REPORT; SCAN lasts exactly N_ENEMY cycles.
REQ-024 Enemy i SHALL count as hit iff valid, x<GRID_W, y<GRID_H and grid bit GRID_H*x+y is 1; out-of-range coordinates never hit and never index grid.
REQ-025 Enemy i SHALL strike player iff valid and |ex-ux|<=HIT_RADIUS and |ey-uy|<=HIT_RADIUS, computed unsigned-safe (no wrap).
REQ-026 grid SHALL be sampled live during SCAN (not snapshotted).
REQ-027 REPORT (one cycle): hit_mask <= accumulated mask; score_update <= |mask; health_update <= any strike; score += popcount(mask), saturating at 65535; health -= 1 if any strike, saturating at 0; then IDLE.
REQ-028 Multiple strikes in one tick SHALL cost exactly one health.
REQ-029 Pulses SHALL be high exactly the cycle after REPORT and low otherwise.
REQ-030 Tick while in SCAN or REPORT SHALL be dropped and set tick_overrun.
REQ-031 start_game mid-scan SHALL abort to IDLE, discard accumulators, no pulses.

Reset
REQ-032 On resetn low: FSM IDLE, counter TICK_DIV-1, score 0, health HEALTH_INIT, hit_mask 0, pulses 0, busy 0, tick_overrun 0, game_over 0; start_game produces the same values synchronously.

Verification (TICK_DIV=16, N_ENEMY=4, HIT_RADIUS=2, HEALTH_INIT=3)
REQ-033 Enemy0 at (10,20) valid, grid bit 1220 set -> first tick: busy 4+1 cycles, score_update one cycle, hit_mask 0001, score 1.
REQ-034 Enemies 1,2,3 all on set pixels, enemy 2 invalid -> hit_mask 1010, score +2.
REQ-035 User (50,50), enemies at (52,48) and (51,51) -> single health_update, health 3->2; enemy at (53,50) -> no strike.
REQ-036 Three striking ticks -> health 0, game_over 1, later ticks produce no scan, busy stays 0.
REQ-037 Enemy at (200,5) with grid all ones -> no hit, no out-of-range access; score unchanged.
REQ-038 resetn pulsed low mid-SCAN -> all outputs at reset values immediately, no pulse; start_game mid-SCAN -> same after next edge.

Source files
------------

// File: rtl/collision_engine_if.sv
// Game-state bus between the collision engine and the rest of the game.
// The master drives the playfield; the slave (the engine) reports hits, score and health.
interface collision_engine_if #(
  parameter int GRID_W  = 160,
  parameter int GRID_H  = 120,
  parameter int N_ENEMY = 4
);
  logic                       start_game;
  logic [GRID_W*GRID_H-1:0]   grid;
  logic [7:0]                 user_x;
  logic [6:0]                 user_y;
  logic [8*N_ENEMY-1:0]       enemy_x;
  logic [7*N_ENEMY-1:0]       enemy_y;
  logic [N_ENEMY-1:0]         enemy_valid;

  logic                       score_update;
  logic                       health_update;
  logic [N_ENEMY-1:0]         hit_mask;
  logic [15:0]                score;
  logic [3:0]                 health;
  logic                       game_over;
  logic                       busy;
  logic                       tick_overrun;

  modport master (
    output start_game, grid, user_x, user_y, enemy_x, enemy_y, enemy_valid,
    input  score_update, health_update, hit_mask, score, health, game_over, busy, tick_overrun
  );

  modport slave (
    input  start_game, grid, user_x, user_y, enemy_x, enemy_y, enemy_valid,
    output score_update, health_update, hit_mask, score, health, game_over, busy, tick_overrun
  );
endinterface

// File: rtl/collision_engine.sv
// Periodic collision checker: each tick snapshots player/enemy positions, scans one
// enemy per cycle against the live projectile bitmap and the player box, then reports.
module collision_engine #(
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  parameter int N_ENEMY     = 4,
  parameter int TICK_DIV    = 1_500_000,
  parameter int HIT_RADIUS  = 2,
  parameter int HEALTH_INIT = 3
) (
  input  logic              clock,
  input  logic              resetn,
  collision_engine_if.slave bus
);
  localparam int CW  = $clog2(TICK_DIV);
  localparam int IXW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
  localparam int PW  = $clog2(GRID_W * GRID_H);
  localparam int MW  = $clog2(N_ENEMY + 1);

  localparam logic [CW-1:0]  CNT_LOAD   = CW'(TICK_DIV - 1);
  localparam logic [IXW-1:0] LAST       = IXW'(N_ENEMY - 1);
  localparam logic [8:0]     X_LIM      = 9'(GRID_W);
  localparam logic [7:0]     Y_LIM      = 8'(GRID_H);
  localparam logic [7:0]     RAD_X      = 8'(HIT_RADIUS);
  localparam logic [6:0]     RAD_Y      = 7'(HIT_RADIUS);
  localparam logic [3:0]     HEALTH_RST = 4'(HEALTH_INIT);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [IXW-1:0]     idx;
  logic [N_ENEMY-1:0] hit_acc;
  logic               strike_acc;
  logic [N_ENEMY-1:0] hit_mask;
  logic               score_update, health_update, tick_overrun;
  logic [15:0]        score;
  logic [3:0]         health;

  logic [7:0]         ux;
  logic [6:0]         uy;
  logic [7:0]         ex_q [N_ENEMY];
  logic [6:0]         ey_q [N_ENEMY];
  logic [N_ENEMY-1:0] ev_q;

  logic               tick, game_over, scan_start;
  logic [7:0]         ex, dx;
  logic [6:0]         ey, dy;
  logic               ev, in_range, enemy_hit, enemy_strike;
  logic [PW-1:0]      pix;
  logic [MW-1:0]      hit_count;
  logic [16:0]        score_sum;
  logic [15:0]        score_next;

  assign tick       = (cnt == '0);
  assign game_over  = (health == 4'd0);
  assign scan_start = (state == IDLE) && tick && !game_over && !bus.start_game;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick && !game_over) state_next = SCAN;
      SCAN:    if (idx == LAST)        state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.start_game) state_next = IDLE;
  end

  // Current enemy under test; out-of-range coordinates are forced to pixel 0 and masked.
  always_comb begin
    ex        = ex_q[idx];
    ey        = ey_q[idx];
    ev        = ev_q[idx];
    in_range  = ({1'b0, ex} < X_LIM) && ({1'b0, ey} < Y_LIM);
    pix       = in_range ? PW'(GRID_H * int'(ex) + int'(ey)) : '0;
    enemy_hit = ev && in_range && bus.grid[pix];
    dx        = (ex >= ux) ? ex - ux : ux - ex;
    dy        = (ey >= uy) ? ey - uy : uy - ey;
    enemy_strike = ev && (dx <= RAD_X) && (dy <= RAD_Y);
  end

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < N_ENEMY; i++) hit_count = hit_count + MW'(hit_acc[i]);
    score_sum  = {1'b0, score} + 17'(hit_count);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // NOTE: the snapshot registers carry no reset; they are always loaded before a scan reads them.
  always_ff @(posedge clock) begin
    if (scan_start) begin
      ux   <= bus.user_x;
      uy   <= bus.user_y;
      ev_q <= bus.enemy_valid;
      for (int i = 0; i < N_ENEMY; i++) begin
        ex_q[i] <= bus.enemy_x[8*i +: 8];
        ey_q[i] <= bus.enemy_y[7*i +: 7];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt           <= CNT_LOAD;
      idx           <= '0;
      hit_acc       <= '0;
      strike_acc    <= 1'b0;
      hit_mask      <= '0;
      score_update  <= 1'b0;
      health_update <= 1'b0;
      score         <= '0;
      health        <= HEALTH_RST;
      tick_overrun  <= 1'b0;
    end else if (bus.start_game) begin
      cnt           <= CNT_LOAD;
      idx           <= '0;
      hit_acc       <= '0;
      strike_acc    <= 1'b0;
      hit_mask      <= '0;
      score_update  <= 1'b0;
      health_update <= 1'b0;
      score         <= '0;
      health        <= HEALTH_RST;
      tick_overrun  <= 1'b0;
    end else begin
      score_update  <= 1'b0;
      health_update <= 1'b0;
      cnt           <= tick ? CNT_LOAD : cnt - 1'b1;
      if (tick && state != IDLE) tick_overrun <= 1'b1;
      case (state)
        IDLE: if (scan_start) begin
          idx        <= '0;
          hit_acc    <= '0;
          strike_acc <= 1'b0;
        end
        SCAN: begin
          hit_acc[idx] <= enemy_hit;
          strike_acc   <= strike_acc | enemy_strike;
          idx          <= idx + 1'b1;
        end
        REPORT: begin
          hit_mask      <= hit_acc;
          score_update  <= |hit_acc;
          health_update <= strike_acc;
          score         <= score_next;
          if (strike_acc && health != 4'd0) health <= health - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.score_update  = score_update;
  assign bus.health_update = health_update;
  assign bus.hit_mask      = hit_mask;
  assign bus.score         = score;
  assign bus.health        = health;
  assign bus.game_over     = game_over;
  assign bus.busy          = (state != IDLE);
  assign bus.tick_overrun  = tick_overrun;
endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine with a 16-cycle tick, four enemies and three health.
module tb_collision_engine;
  localparam int GRID_W = 160, GRID_H = 120, N_ENEMY = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  collision_engine_if #(.GRID_W(GRID_W), .GRID_H(GRID_H), .N_ENEMY(N_ENEMY)) bus ();

  collision_engine #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .N_ENEMY(N_ENEMY),
    .TICK_DIV(16), .HIT_RADIUS(2), .HEALTH_INIT(3)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_enemy(input int i, input int x, input int y, input bit v);
    bus.enemy_x[8*i +: 8] = 8'(x);
    bus.enemy_y[7*i +: 7] = 7'(y);
    bus.enemy_valid[i]    = v;
  endtask

  task automatic set_user(input int x, input int y);
    bus.user_x = 8'(x);
    bus.user_y = 7'(y);
  endtask

  task automatic wait_busy(output int waited, output bit seen);
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      waited++;
      if (bus.busy) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Samples a 12-cycle window starting at the cycle busy was first seen.
  task automatic finish_tick(output int busy_cyc, output int s_p, output int h_p, output int s_at);
    busy_cyc = 0; s_p = 0; h_p = 0; s_at = -1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clock);
      if (bus.busy) busy_cyc++;
      if (bus.score_update) begin
        s_p++;
        if (s_at < 0) s_at = k;
      end
      if (bus.health_update) h_p++;
    end
  endtask

  task automatic run_tick(output int waited, output int busy_cyc, output int s_p,
                          output int h_p, output int s_at);
    bit seen;
    wait_busy(waited, seen);
    n_compared++;
    if (seen !== 1'b1) begin
      n_mismatched++;
      $display("FAIL tick_start: busy never rose within 40 cycles");
    end
    finish_tick(busy_cyc, s_p, h_p, s_at);
  endtask

  task automatic count_pulses(input int cycles, output int p);
    p = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (bus.score_update || bus.health_update || bus.busy) p++;
    end
  endtask

  task automatic test_reset();
    bus.start_game = 1'b0;
    bus.grid = '0;
    bus.enemy_valid = '0;
    bus.enemy_x = '0;
    bus.enemy_y = '0;
    set_user(150, 100);
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    n_compared += 7;
    if (bus.score !== 16'd0) begin n_mismatched++; $display("FAIL reset_score: got %0d want 0", bus.score); end
    if (bus.health !== 4'd3) begin n_mismatched++; $display("FAIL reset_health: got %0d want 3", bus.health); end
    if (bus.hit_mask !== 4'b0000) begin n_mismatched++; $display("FAIL reset_mask: got %b want 0000", bus.hit_mask); end
    if ({bus.score_update, bus.health_update} !== 2'b00) begin n_mismatched++; $display("FAIL reset_pulses: got %b want 00", {bus.score_update, bus.health_update}); end
    if (bus.busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.tick_overrun !== 1'b0) begin n_mismatched++; $display("FAIL reset_overrun: got %b want 0", bus.tick_overrun); end
    if (bus.game_over !== 1'b0) begin n_mismatched++; $display("FAIL reset_game_over: got %b want 0", bus.game_over); end
    resetn = 1'b1;
  endtask

  task automatic test_single_hit();
    int waited, busy_cyc, s_p, h_p, s_at;
    bus.grid[1220] = 1'b1;
    set_enemy(0, 10, 20, 1'b1);
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared += 9;
    if (waited !== 16) begin n_mismatched++; $display("FAIL first_tick_latency: got %0d want 16", waited); end
    if (busy_cyc !== 5) begin n_mismatched++; $display("FAIL busy_cycles: got %0d want 5", busy_cyc); end
    if (s_at !== 5) begin n_mismatched++; $display("FAIL score_pulse_position: got %0d want 5", s_at); end
    if (s_p !== 1) begin n_mismatched++; $display("FAIL single_score_pulses: got %0d want 1", s_p); end
    if (h_p !== 0) begin n_mismatched++; $display("FAIL single_health_pulses: got %0d want 0", h_p); end
    if (bus.hit_mask !== 4'b0001) begin n_mismatched++; $display("FAIL single_mask: got %b want 0001", bus.hit_mask); end
    if (bus.score !== 16'd1) begin n_mismatched++; $display("FAIL single_score: got %0d want 1", bus.score); end
    if (bus.health !== 4'd3) begin n_mismatched++; $display("FAIL single_health: got %0d want 3", bus.health); end
    repeat (3) @(negedge clock);
    if (bus.hit_mask !== 4'b0001) begin n_mismatched++; $display("FAIL mask_held: got %b want 0001", bus.hit_mask); end
  endtask

  task automatic test_multi_hit();
    int waited, busy_cyc, s_p, h_p, s_at;
    set_user(100, 100);
    bus.grid = '0;
    bus.grid[3640]  = 1'b1;
    bus.grid[3761]  = 1'b1;
    bus.grid[19199] = 1'b1;
    set_enemy(0, 11, 20, 1'b1);
    set_enemy(1, 30, 40, 1'b1);
    set_enemy(2, 31, 41, 1'b0);
    set_enemy(3, 159, 119, 1'b1);
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared += 3;
    if (bus.hit_mask !== 4'b1010) begin n_mismatched++; $display("FAIL multi_mask: got %b want 1010", bus.hit_mask); end
    if (bus.score !== 16'd3) begin n_mismatched++; $display("FAIL multi_score: got %0d want 3", bus.score); end
    if (s_p !== 1) begin n_mismatched++; $display("FAIL multi_score_pulses: got %0d want 1", s_p); end
  endtask

  task automatic test_live_grid();
    int waited, busy_cyc, s_p, h_p, s_at;
    bit seen;
    bus.grid = '0;
    bus.enemy_valid = '0;
    set_enemy(0, 10, 20, 1'b1);
    wait_busy(waited, seen);
    bus.grid[1220] = 1'b1;
    finish_tick(busy_cyc, s_p, h_p, s_at);
    n_compared += 2;
    if (bus.hit_mask !== 4'b0001) begin n_mismatched++; $display("FAIL live_grid_mask: got %b want 0001", bus.hit_mask); end
    if (bus.score !== 16'd4) begin n_mismatched++; $display("FAIL live_grid_score: got %0d want 4", bus.score); end
  endtask

  task automatic test_out_of_range();
    int waited, busy_cyc, s_p, h_p, s_at;
    bus.grid = '1;
    bus.enemy_valid = '0;
    set_enemy(0, 200, 5, 1'b1);
    set_enemy(1, 10, 120, 1'b1);
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared += 3;
    if (bus.hit_mask !== 4'b0000) begin n_mismatched++; $display("FAIL oor_mask: got %b want 0000", bus.hit_mask); end
    if (bus.score !== 16'd4) begin n_mismatched++; $display("FAIL oor_score: got %0d want 4", bus.score); end
    if (s_p !== 0) begin n_mismatched++; $display("FAIL oor_score_pulses: got %0d want 0", s_p); end
  endtask

  task automatic test_strike();
    int waited, busy_cyc, s_p, h_p, s_at;
    bus.grid = '0;
    bus.enemy_valid = '0;
    set_user(50, 50);
    set_enemy(0, 52, 48, 1'b1);
    set_enemy(1, 51, 51, 1'b1);
    set_enemy(2, 53, 50, 1'b1);
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared += 4;
    if (h_p !== 1) begin n_mismatched++; $display("FAIL strike_pulses: got %0d want 1", h_p); end
    if (bus.health !== 4'd2) begin n_mismatched++; $display("FAIL strike_health: got %0d want 2", bus.health); end
    if (s_p !== 0) begin n_mismatched++; $display("FAIL strike_score_pulses: got %0d want 0", s_p); end
    if (bus.score !== 16'd4) begin n_mismatched++; $display("FAIL strike_score: got %0d want 4", bus.score); end
  endtask

  task automatic test_no_strike();
    int waited, busy_cyc, s_p, h_p, s_at;
    bus.enemy_valid = '0;
    set_user(50, 50);
    set_enemy(0, 53, 50, 1'b1);
    set_enemy(1, 50, 53, 1'b1);
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared += 2;
    if (h_p !== 0) begin n_mismatched++; $display("FAIL near_miss_pulses: got %0d want 0", h_p); end
    if (bus.health !== 4'd2) begin n_mismatched++; $display("FAIL near_miss_health: got %0d want 2", bus.health); end
    set_user(0, 0);
    set_enemy(0, 254, 0, 1'b1);
    set_enemy(1, 0, 126, 1'b1);
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared += 2;
    if (h_p !== 0) begin n_mismatched++; $display("FAIL wrap_pulses: got %0d want 0", h_p); end
    if (bus.health !== 4'd2) begin n_mismatched++; $display("FAIL wrap_health: got %0d want 2", bus.health); end
  endtask

  task automatic test_game_over();
    int waited, busy_cyc, s_p, h_p, s_at;
    bit seen;
    bus.enemy_valid = '0;
    set_user(50, 50);
    set_enemy(0, 50, 50, 1'b1);
    for (int t = 0; t < 2; t++) begin
      run_tick(waited, busy_cyc, s_p, h_p, s_at);
      n_compared++;
      if (h_p !== 1) begin n_mismatched++; $display("FAIL go_tick%0d_pulses: got %0d want 1", t, h_p); end
    end
    n_compared += 4;
    if (bus.health !== 4'd0) begin n_mismatched++; $display("FAIL go_health: got %0d want 0", bus.health); end
    if (bus.game_over !== 1'b1) begin n_mismatched++; $display("FAIL go_flag: got %b want 1", bus.game_over); end
    wait_busy(waited, seen);
    if (seen !== 1'b0) begin n_mismatched++; $display("FAIL go_no_scan: busy rose after %0d cycles, want none", waited); end
    if (bus.health !== 4'd0) begin n_mismatched++; $display("FAIL go_health_held: got %0d want 0", bus.health); end
  endtask

  task automatic test_no_overrun();
    n_compared++;
    if (bus.tick_overrun !== 1'b0) begin n_mismatched++; $display("FAIL overrun_flag: got %b want 0", bus.tick_overrun); end
  endtask

  task automatic test_start_game();
    bus.start_game = 1'b1;
    @(negedge clock);
    bus.start_game = 1'b0;
    n_compared += 4;
    if (bus.health !== 4'd3) begin n_mismatched++; $display("FAIL start_health: got %0d want 3", bus.health); end
    if (bus.score !== 16'd0) begin n_mismatched++; $display("FAIL start_score: got %0d want 0", bus.score); end
    if (bus.game_over !== 1'b0) begin n_mismatched++; $display("FAIL start_game_over: got %b want 0", bus.game_over); end
    if (bus.hit_mask !== 4'b0000) begin n_mismatched++; $display("FAIL start_mask: got %b want 0000", bus.hit_mask); end
  endtask

  task automatic test_abort_start();
    int waited, busy_cyc, s_p, h_p, s_at, p;
    bit seen;
    bus.grid = '0;
    bus.grid[1220] = 1'b1;
    bus.enemy_valid = '0;
    set_user(150, 100);
    set_enemy(0, 10, 20, 1'b1);
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared += 2;
    if (waited !== 16) begin n_mismatched++; $display("FAIL restart_latency: got %0d want 16", waited); end
    if (bus.score !== 16'd1) begin n_mismatched++; $display("FAIL restart_score: got %0d want 1", bus.score); end
    wait_busy(waited, seen);
    bus.start_game = 1'b1;
    @(negedge clock);
    bus.start_game = 1'b0;
    n_compared += 5;
    if (bus.busy !== 1'b0) begin n_mismatched++; $display("FAIL abort_sg_busy: got %b want 0", bus.busy); end
    if (bus.score !== 16'd0) begin n_mismatched++; $display("FAIL abort_sg_score: got %0d want 0", bus.score); end
    if (bus.hit_mask !== 4'b0000) begin n_mismatched++; $display("FAIL abort_sg_mask: got %b want 0000", bus.hit_mask); end
    if (bus.health !== 4'd3) begin n_mismatched++; $display("FAIL abort_sg_health: got %0d want 3", bus.health); end
    count_pulses(8, p);
    if (p !== 0) begin n_mismatched++; $display("FAIL abort_sg_activity: got %0d want 0", p); end
  endtask

  task automatic test_abort_reset();
    int waited, busy_cyc, s_p, h_p, s_at, p;
    bit seen;
    run_tick(waited, busy_cyc, s_p, h_p, s_at);
    n_compared++;
    if (bus.score !== 16'd1) begin n_mismatched++; $display("FAIL prereset_score: got %0d want 1", bus.score); end
    wait_busy(waited, seen);
    resetn = 1'b0;
    #1;
    n_compared += 5;
    if (bus.busy !== 1'b0) begin n_mismatched++; $display("FAIL abort_rst_busy: got %b want 0", bus.busy); end
    if (bus.score !== 16'd0) begin n_mismatched++; $display("FAIL abort_rst_score: got %0d want 0", bus.score); end
    if (bus.hit_mask !== 4'b0000) begin n_mismatched++; $display("FAIL abort_rst_mask: got %b want 0000", bus.hit_mask); end
    if (bus.health !== 4'd3) begin n_mismatched++; $display("FAIL abort_rst_health: got %0d want 3", bus.health); end
    @(negedge clock);
    resetn = 1'b1;
    count_pulses(8, p);
    if (p !== 0) begin n_mismatched++; $display("FAIL abort_rst_activity: got %0d want 0", p); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_live_grid();
    test_out_of_range();
    test_strike();
    test_no_strike();
    test_game_over();
    test_no_overrun();
    test_start_game();
    test_abort_start();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
